elevator_request_scheduler: RTL and testbench

Latches floor calls from car and hall buttons and schedules them with a LOOK policy. Issues one target floor at a time to the elevator motion controller over a valid/ready handshake, waits for arrival, then holds the door open. Sits between the button inputs and the motion/state-machine block. current_floor comes from the motion block and also drives the 7-segment display path.

---
 rtl/elevator_request_scheduler.sv | 155 +++++++++++++++
 tb/tb_elevator_request_scheduler.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_request_scheduler.sv
// LOOK-policy floor call scheduler: latches button calls, hands one target at a
// time to the motion controller over valid/ready, then holds the door at each stop.
module elevator_request_scheduler #(
    parameter int NUM_FLOORS = 10,
    parameter int DOOR_HOLD  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] call_btn,
    input  logic [3:0]            current_floor,
    input  logic                  arrived,
    output logic [3:0]            target_floor,
    output logic                  target_valid,
    input  logic                  target_ready,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  direction_up,
    output logic                  door_open,
    output logic                  busy
);
    localparam int HOLD_W = (DOOR_HOLD > 1) ? $clog2(DOOR_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(DOOR_HOLD - 1);

    typedef enum logic [1:0] {IDLE, DISPATCH, TRAVEL, DOOR} state_t;

    state_t                  state_reg;
    logic [HOLD_W-1:0]       hold_cnt_reg;
    logic [NUM_FLOORS-1:0]   pending_reg;
    logic [NUM_FLOORS-1:0]   cf_hit;
    logic [NUM_FLOORS-1:0]   tgt_hit;
    logic [NUM_FLOORS-1:0]   above_mask;
    logic [NUM_FLOORS-1:0]   below_mask;
    logic [NUM_FLOORS-1:0]   clear_mask;
    logic                    here_call;
    logic                    arrive_ok;
    logic                    found_above;
    logic                    found_below;
    logic [3:0]              lowest_above;
    logic [3:0]              highest_below;
    logic [3:0]              target_next;
    logic                    direction_next;

    // A current_floor beyond the served range matches no bit, so it simply
    // sees every pending call as below it.
    generate
        for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_floor
            assign cf_hit[gi]     = (current_floor == 4'(gi));
            assign tgt_hit[gi]    = (target_floor == 4'(gi));
            assign above_mask[gi] = pending_reg[gi] && (4'(gi) > current_floor);
            assign below_mask[gi] = pending_reg[gi] && (4'(gi) < current_floor);
        end
    endgenerate

    assign here_call = |((pending_reg | call_btn) & cf_hit);
    assign arrive_ok = arrived && (current_floor == target_floor);
    assign pending   = pending_reg;
    assign busy      = (state_reg != IDLE);

    always_comb begin
        found_above   = 1'b0;
        found_below   = 1'b0;
        lowest_above  = 4'd0;
        highest_below = 4'd0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (above_mask[i] && !found_above) begin
                found_above  = 1'b1;
                lowest_above = 4'(i);
            end
            if (below_mask[i]) begin
                found_below   = 1'b1;
                highest_below = 4'(i);
            end
        end
    end

    // Keep sweeping in the current direction; reverse only when it runs dry.
    always_comb begin
        target_next    = target_floor;
        direction_next = direction_up;
        if (direction_up) begin
            if (found_above) begin
                target_next = lowest_above;
            end else begin
                direction_next = 1'b0;
                target_next    = highest_below;
            end
        end else begin
            if (found_below) begin
                target_next = highest_below;
            end else begin
                direction_next = 1'b1;
                target_next    = lowest_above;
            end
        end
    end

    always_comb begin
        clear_mask = '0;
        case (state_reg)
            IDLE:    if (here_call) clear_mask = cf_hit;
            TRAVEL:  if (arrive_ok) clear_mask = tgt_hit;
            DOOR:    clear_mask = cf_hit;
            default: clear_mask = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            pending_reg  <= '0;
            target_floor <= 4'd0;
            target_valid <= 1'b0;
            direction_up <= 1'b1;
            door_open    <= 1'b0;
            hold_cnt_reg <= '0;
        end else begin
            pending_reg <= (pending_reg | call_btn) & ~clear_mask;
            case (state_reg)
                IDLE: begin
                    if (here_call) begin
                        state_reg    <= DOOR;
                        door_open    <= 1'b1;
                        hold_cnt_reg <= HOLD_LAST;
                    end else if (|pending_reg) begin
                        state_reg    <= DISPATCH;
                        target_floor <= target_next;
                        direction_up <= direction_next;
                        target_valid <= 1'b1;
                    end
                end
                DISPATCH: begin
                    if (target_ready) begin
                        target_valid <= 1'b0;
                        state_reg    <= TRAVEL;
                    end
                end
                TRAVEL: begin
                    if (arrive_ok) begin
                        state_reg    <= DOOR;
                        door_open    <= 1'b1;
                        hold_cnt_reg <= HOLD_LAST;
                    end
                end
                DOOR: begin
                    if (hold_cnt_reg == '0) begin
                        door_open <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg - 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Scoreboarded bench: expected target floors are queued as calls are placed and
// checked when each target handshake completes.
module tb_elevator_request_scheduler;
    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  call_btn;
    logic [3:0]  current_floor;
    logic        arrived;
    logic [3:0]  target_floor;
    logic        target_valid;
    logic        target_ready;
    logic [9:0]  pending;
    logic        direction_up;
    logic        door_open;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int exp_q[$];
    int exp_f;

    elevator_request_scheduler #(.NUM_FLOORS(10), .DOOR_HOLD(16)) dut (
        .clk(clk),
        .reset(reset),
        .call_btn(call_btn),
        .current_floor(current_floor),
        .arrived(arrived),
        .target_floor(target_floor),
        .target_valid(target_valid),
        .target_ready(target_ready),
        .pending(pending),
        .direction_up(direction_up),
        .door_open(door_open),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Handshake monitor: a transfer happens at the next rising edge.
    always @(negedge clk) begin
        if (!reset && target_valid && target_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL target_xfer: got floor %0d, required no transfer", target_floor);
            end else begin
                exp_f = exp_q.pop_front();
                if (target_floor !== 4'(exp_f)) begin
                    failures++;
                    $display("FAIL target_xfer: got floor %0d, required %0d", target_floor, exp_f);
                end else begin
                    $display("xfer target_floor=%0d dir_up=%0d", target_floor, direction_up);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!target_valid && n < 30) begin
            tick();
            n++;
        end
        checks++;
        if (!target_valid) begin
            failures++;
            $display("FAIL wait_valid: target_valid=%0d after %0d cycles, required 1", target_valid, n);
        end
    endtask

    task automatic wait_door_done();
        int n = 0;
        while (door_open && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (door_open !== 1'b0) begin
            failures++;
            $display("FAIL wait_door_done: door_open=%0d after %0d cycles, required 0", door_open, n);
        end
    endtask

    // Acts as the motion controller for one stop with target_ready held high.
    task automatic serve_one();
        wait_valid();
        tick();
        current_floor = target_floor;
        arrived = 1'b1;
        tick();
        arrived = 1'b0;
        checks++;
        if (door_open !== 1'b1) begin
            failures++;
            $display("FAIL serve_door: door_open=%0d at floor %0d, required 1", door_open, current_floor);
        end
        wait_door_done();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        call_btn = '0;
        current_floor = 4'd0;
        arrived = 1'b0;
        target_ready = 1'b0;
        #13;
        checks++;
        if ({busy, target_valid, door_open, direction_up, target_floor, pending} !== {4'b0001, 4'd0, 10'd0}) begin
            failures++;
            $display("FAIL reset_state: busy=%0d valid=%0d door=%0d up=%0d tf=%0d pend=%b, required 0 0 0 1 0 0",
                     busy, target_valid, door_open, direction_up, target_floor, pending);
        end
        reset = 1'b0;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_single_call();
        int n;
        target_ready = 1'b1;
        current_floor = 4'd0;
        call_btn = 10'b00_0000_1000;
        exp_q.push_back(3);
        tick();
        call_btn = '0;
        checks++;
        if (pending !== 10'b00_0000_1000 || target_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_latch: pending=%b valid=%0d, required 0000001000 0", pending, target_valid);
        end
        tick();
        checks++;
        if (target_valid !== 1'b1 || target_floor !== 4'd3) begin
            failures++;
            $display("FAIL single_dispatch: valid=%0d tf=%0d, required 1 3", target_valid, target_floor);
        end
        tick();
        checks++;
        if (target_valid !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL single_travel: valid=%0d busy=%0d, required 0 1", target_valid, busy);
        end
        current_floor = 4'd3;
        arrived = 1'b1;
        tick();
        arrived = 1'b0;
        checks++;
        if (door_open !== 1'b1 || pending !== 10'd0) begin
            failures++;
            $display("FAIL single_arrive: door=%0d pending=%b, required 1 0", door_open, pending);
        end
        n = 1;
        while (n < 40) begin
            tick();
            if (!door_open) break;
            n++;
        end
        checks++;
        if (n != 16) begin
            failures++;
            $display("FAIL single_door_len: door_open cycles=%0d, required 16", n);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL single_idle: busy=%0d, required 0", busy);
        end
        $display("test_single_call done");
    endtask

    task automatic test_here_call();
        logic saw_valid = 1'b0;
        current_floor = 4'd0;
        call_btn = 10'b00_0000_0001;
        tick();
        call_btn = '0;
        checks++;
        if (door_open !== 1'b1 || busy !== 1'b1 || pending !== 10'd0) begin
            failures++;
            $display("FAIL here_door: door=%0d busy=%0d pending=%b, required 1 1 0", door_open, busy, pending);
        end
        for (int i = 0; i < 20; i++) begin
            if (target_valid) saw_valid = 1'b1;
            tick();
        end
        checks++;
        if (saw_valid !== 1'b0 || door_open !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL here_nohandshake: saw_valid=%0d door=%0d busy=%0d, required 0 0 0", saw_valid, door_open, busy);
        end
        $display("test_here_call done");
    endtask

    task automatic test_look();
        current_floor = 4'd5;
        call_btn = 10'b10_1000_0100;
        exp_q.push_back(7);
        exp_q.push_back(9);
        exp_q.push_back(2);
        tick();
        call_btn = '0;
        serve_one();
        checks++;
        if (direction_up !== 1'b1) begin
            failures++;
            $display("FAIL look_dir_up: direction_up=%0d, required 1", direction_up);
        end
        serve_one();
        wait_valid();
        checks++;
        if (direction_up !== 1'b0 || target_floor !== 4'd2) begin
            failures++;
            $display("FAIL look_reverse: up=%0d tf=%0d, required 0 2", direction_up, target_floor);
        end
        serve_one();
        $display("test_look done");
    endtask

    task automatic test_backpressure();
        target_ready = 1'b0;
        call_btn = 10'b01_0000_0000;
        exp_q.push_back(8);
        tick();
        call_btn = '0;
        wait_valid();
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (target_valid !== 1'b1 || target_floor !== 4'd8) begin
                failures++;
                $display("FAIL bp_hold[%0d]: valid=%0d tf=%0d, required 1 8", k, target_valid, target_floor);
            end
            call_btn = (k == 1) ? 10'b00_0000_0010 : 10'd0;
            tick();
        end
        call_btn = '0;
        checks++;
        if (pending !== 10'b01_0000_0010 || target_floor !== 4'd8) begin
            failures++;
            $display("FAIL bp_latch: pending=%b tf=%0d, required 0100000010 8", pending, target_floor);
        end
        exp_q.push_back(1);
        target_ready = 1'b1;
        serve_one();
        serve_one();
        $display("test_backpressure done");
    endtask

    task automatic test_spurious();
        arrived = 1'b1;
        tick();
        arrived = 1'b0;
        checks++;
        if (busy !== 1'b0 || pending !== 10'd0 || door_open !== 1'b0) begin
            failures++;
            $display("FAIL spur_idle_arrive: busy=%0d pending=%b door=%0d, required 0 0 0", busy, pending, door_open);
        end
        call_btn = 10'b00_0100_0000;
        exp_q.push_back(6);
        tick();
        call_btn = '0;
        wait_valid();
        tick();
        current_floor = 4'd3;
        arrived = 1'b1;
        tick();
        arrived = 1'b0;
        checks++;
        if (busy !== 1'b1 || door_open !== 1'b0 || target_valid !== 1'b0 || pending !== 10'b00_0100_0000) begin
            failures++;
            $display("FAIL spur_wrong_floor: busy=%0d door=%0d valid=%0d pending=%b, required 1 0 0 0001000000",
                     busy, door_open, target_valid, pending);
        end
        current_floor = 4'd6;
        arrived = 1'b1;
        tick();
        arrived = 1'b0;
        call_btn = 10'b00_0100_0000;
        tick();
        call_btn = '0;
        tick();
        checks++;
        if (pending !== 10'd0 || door_open !== 1'b1) begin
            failures++;
            $display("FAIL spur_door_absorb: pending=%b door=%0d, required 0 1", pending, door_open);
        end
        wait_door_done();
        tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL spur_after_door: busy=%0d, required 0", busy);
        end
        $display("test_spurious done");
    endtask

    task automatic test_reset_mid();
        call_btn = 10'b00_0001_0000;
        exp_q.push_back(4);
        tick();
        call_btn = '0;
        wait_valid();
        tick();
        call_btn = 10'b00_0100_0000;
        tick();
        call_btn = '0;
        checks++;
        if (pending !== 10'b00_0101_0000 || busy !== 1'b1 || direction_up !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_pre: pending=%b busy=%0d up=%0d, required 0001010000 1 0", pending, busy, direction_up);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({busy, target_valid, door_open, direction_up, target_floor, pending} !== {4'b0001, 4'd0, 10'd0}) begin
            failures++;
            $display("FAIL rstmid_async: busy=%0d valid=%0d door=%0d up=%0d tf=%0d pend=%b, required 0 0 0 1 0 0",
                     busy, target_valid, door_open, direction_up, target_floor, pending);
        end
        #2 reset = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || pending !== 10'd0) begin
            failures++;
            $display("FAIL rstmid_post: busy=%0d pending=%b, required 0 0", busy, pending);
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_single_call();
        test_here_call();
        test_look();
        test_backpressure();
        test_spurious();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d targets outstanding, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
